vmd_burst_sender: RTL and testbench



---
 rtl/vmd_pkg.sv | 19 +
 rtl/vmd_sync_fifo.sv | 65 ++++++
 rtl/vmd_burst_sender.sv | 139 +++++++++++++
 tb/tb_vmd_burst_sender.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vmd_pkg.sv
// vmd_pkg: shared types and helpers for the vmd_burst_sender datapath.
// Holds the FSM state encoding, the debug ASCII word width and the
// FIFO occupancy width helper used by the top and the FIFO.
package vmd_pkg;

    typedef enum logic [2:0] {
        SM_IDLE  = 3'b000,
        SM_SEND  = 3'b001,
        SM_WAIT1 = 3'b010
    } sm_state_t;

    localparam int ASCII_W = 64;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vmd_sync_fifo.sv
// vmd_sync_fifo: single-clock FIFO with registered memory and a
// combinational head read. Pointers wrap modulo DEPTH (power of 2).
// Writes are refused when full even if a read happens in the same cycle.
module vmd_sync_fifo
    import vmd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              wr_fire;
    logic              rd_fire;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array: data only, never reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vmd_burst_sender.sv
// vmd_burst_sender: buffers upstream words and releases them downstream
// in fixed BURST_LEN bursts, followed by a WAIT_CYC idle gap.
// A burst starts only once the whole burst is already buffered, so the
// FIFO can never run dry mid-burst.
// Optional macro VMD_ASCII_STATE_EN adds dbg_state_ascii, an 8-character
// ASCII rendering of the FSM state for waveform viewing.
module vmd_burst_sender
    import vmd_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int WAIT_CYC  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy,
    output logic [cnt_w(DEPTH)-1:0]   fifo_count
`ifdef VMD_ASCII_STATE_EN
    ,
    output logic [ASCII_W-1:0]        dbg_state_ascii
);
`else
);
`endif

    localparam int CNT_W  = cnt_w(DEPTH);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [3:0]        GAP_LAST  = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
    localparam logic              ONE_BEAT  = (BURST_LEN == 1);

    sm_state_t         state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_nxt;
    logic [3:0]        gap_cnt;
    logic              fifo_full;
    logic              beat;

    assign in_ready = !fifo_full;
    assign beat     = out_valid && out_ready;
    assign beat_nxt = beat_cnt + 1'b1;

    vmd_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (beat),
        .rd_data (out_data),
        .count   (fifo_count),
        .full    (fifo_full)
    );

    // Burst FSM with beat/gap counters; out_valid, out_last and busy are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SM_IDLE;
            beat_cnt  <= '0;
            gap_cnt   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                SM_IDLE: begin
                    if (fifo_count >= BURST_CNT) begin
                        state     <= SM_SEND;
                        beat_cnt  <= '0;
                        out_valid <= 1'b1;
                        out_last  <= ONE_BEAT;
                        busy      <= 1'b1;
                    end
                end
                SM_SEND: begin
                    if (out_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt  <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (WAIT_CYC > 0) begin
                                state   <= SM_WAIT1;
                                gap_cnt <= '0;
                            end else begin
                                state <= SM_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            beat_cnt <= beat_nxt;
                            out_last <= (beat_nxt == LAST_BEAT);
                        end
                    end
                end
                SM_WAIT1: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= SM_IDLE;
                        gap_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= SM_IDLE;
                    beat_cnt  <= '0;
                    gap_cnt   <= '0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef VMD_ASCII_STATE_EN
    // Debug-only ASCII name of the current state.
    always_comb begin
        dbg_state_ascii = "%Error  ";
        case (state)
            SM_IDLE:  dbg_state_ascii = "idle    ";
            SM_SEND:  dbg_state_ascii = "send    ";
            SM_WAIT1: dbg_state_ascii = "wait1   ";
            default:  dbg_state_ascii = "%Error  ";
        endcase
    end
`endif

endmodule

// File: tb/tb_vmd_burst_sender.sv
// tb_vmd_burst_sender: directed bench for vmd_burst_sender with a
// data scoreboard fed on every write and drained on every output beat.
module tb_vmd_burst_sender;
    import vmd_pkg::*;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 8;
    localparam int BURST_LEN = 4;
    localparam int WAIT_CYC  = 2;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic [CNT_W-1:0]  fifo_count;
`ifdef VMD_ASCII_STATE_EN
    logic [63:0]       dbg_state_ascii;
`endif

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [DATA_W-1:0] sb [$];
    int                mon_beat = 0;

    always #5 clk = ~clk;

    vmd_burst_sender #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .BURST_LEN (BURST_LEN),
        .WAIT_CYC  (WAIT_CYC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_last        (out_last),
        .out_ready       (out_ready),
        .busy            (busy),
`ifdef VMD_ASCII_STATE_EN
        .fifo_count      (fifo_count),
        .dbg_state_ascii (dbg_state_ascii)
`else
        .fifo_count      (fifo_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for one edge; the caller knows it will be accepted.
    task automatic put(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        sb.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int i;
        for (i = 0; i < maxc; i++) begin
            if (busy === 1'b0 && fifo_count === '0) break;
            tick();
        end
        check(tag, 64'(i < maxc), 64'd1);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),   64'd1);
        check({tag, "_out_valid"}, 64'(out_valid),  64'd0);
        check({tag, "_out_last"},  64'(out_last),   64'd0);
        check({tag, "_busy"},      64'(busy),       64'd0);
        check({tag, "_count"},     64'(fifo_count), 64'd0);
`ifdef VMD_ASCII_STATE_EN
        check({tag, "_ascii"},     dbg_state_ascii, "idle    ");
`endif
    endtask

    // Output monitor: every accepted beat must match the scoreboard head,
    // and out_last must mark exactly every BURST_LEN-th beat.
    always @(negedge clk) begin
        logic [DATA_W-1:0] exp_d;
        if (rst === 1'b1) begin
            sb.delete();
            mon_beat = 0;
        end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_d = (sb.size() > 0) ? sb.pop_front() : 'x;
            check("beat_data", 64'(out_data), 64'(exp_d));
            check("beat_last", 64'(out_last), 64'(mon_beat == BURST_LEN - 1));
            mon_beat = (mon_beat == BURST_LEN - 1) ? 0 : mon_beat + 1;
        end
    end

    initial begin
        logic [DATA_W-1:0] d;

        // Reset and idle state
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check_idle("reset");

        // Three words are below the burst threshold
        out_ready = 1'b1;
        put(8'h11); put(8'h22); put(8'h33);
        tick();
        check("below_thr_valid", 64'(out_valid),  64'd0);
        check("below_thr_count", 64'(fifo_count), 64'd3);
        check("below_thr_busy",  64'(busy),       64'd0);

        // Fourth word: burst two edges after it is presented
        put(8'h44);
        check("thr_edge1_valid", 64'(out_valid),  64'd0);
        check("thr_edge1_count", 64'(fifo_count), 64'd4);
        tick();
        check("thr_edge2_valid", 64'(out_valid), 64'd1);
        check("thr_edge2_busy",  64'(busy),      64'd1);
        for (int i = 0; i < 4; i++) begin
            d = 8'(17 * (i + 1));
            check("burst_data",  64'(out_data),  64'(d));
            check("burst_last",  64'(out_last),  64'(i == 3));
            check("burst_valid", 64'(out_valid), 64'd1);
            tick();
        end
        check("gap1_valid", 64'(out_valid), 64'd0);
        check("gap1_busy",  64'(busy),      64'd1);
        tick();
        check("gap2_valid", 64'(out_valid), 64'd0);
        check("gap2_busy",  64'(busy),      64'd1);
        tick();
        check("after_gap_busy", 64'(busy), 64'd0);

        // Backpressure on the second beat
        out_ready = 1'b0;
        put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        tick();
        check("bp_start_valid", 64'(out_valid), 64'd1);
        check("bp_start_data",  64'(out_data),  64'h11);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_data",  64'(out_data),  64'h22);
            check("bp_hold_last",  64'(out_last),  64'd0);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        wait_drain("bp_drain", 40);

        // Fill to DEPTH with the consumer stalled; a 9th word is refused
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            put(8'(8'h80 + i));
        end
        check("full_in_ready", 64'(in_ready),   64'd0);
        check("full_count",    64'(fifo_count), 64'd8);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        in_valid = 1'b0;
        check("full_drop_count", 64'(fifo_count), 64'd8);
        check("full_drop_ready", 64'(in_ready),   64'd0);
        out_ready = 1'b1;
        wait_drain("full_drain", 80);

        // Streaming writes while a burst is sent; pointers wrap past 7
        put(8'h51); put(8'h52); put(8'h53); put(8'h54);
        check("stream_count4", 64'(fifo_count), 64'd4);
        put(8'h55);
        check("stream_count5",  64'(fifo_count), 64'd5);
        check("stream_valid",   64'(out_valid),  64'd1);
        for (int i = 0; i < 4; i++) begin
            put(8'(8'h56 + i));
            check("stream_rw_count", 64'(fifo_count), 64'd5);
        end
        put(8'h5A);
        check("stream_gap_count", 64'(fifo_count), 64'd6);
        put(8'h5B); put(8'h5C);
        wait_drain("stream_drain", 80);

        // Reset on the second beat of a burst
        put(8'h61); put(8'h62); put(8'h63); put(8'h64);
        tick();
        check("rst_burst_data", 64'(out_data), 64'h61);
        tick();
        check("rst_beat2_data", 64'(out_data), 64'h62);
        rst = 1'b1;
        tick();
        check_idle("mid_rst");
        rst = 1'b0;
        tick();
        check_idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
